// File: rtl/fir_coef_seq.sv
// rtl/fir_coef_seq.sv - FIR coefficient load/commit sequencer
//
// Purpose:
//   Accepts one coefficient set over a valid/ready stream and writes it tap by
//   tap into the FIR shadow ("mirror") registers. It then waits for the next
//   FIR input sample strobe and issues a single commit pulse, so that the
//   active taps change between samples and never part-way through one.
//   A stall on the stream longer than TIMEOUT cycles abandons the load and
//   raises a sticky error.
//
// Optional feature:
//   `define FIR_COEF_SEQ_SYM_EN  -> symmetric loading. The stream carries
//   ORDER/2+1 beats. Beat k writes tap k and then tap ORDER-k in the next cycle.
//   The stream is held off (s_ready=0) while the mirrored write goes out.
//
// Ports:
//   clk, resetn          clock, asynchronous active-low reset
//   start                begin loading a set (honoured only when idle)
//   s_valid/s_ready      coefficient stream handshake, s_data = coefficient,
//                        tap 0 first
//   sample_valid         FIR sample strobe; the commit lines up with it
//   coef_wr/addr/data    registered one-cycle tap write to the mirror
//   coef_mirr            one-cycle commit of the mirror to the active taps
//   busy                 sequence in progress
//   done                 one-cycle strobe, coincident with coef_mirr
//   err                  sticky timeout flag, cleared by the next start

module fir_coef_seq #(
  parameter int ORDER      = 8,
  parameter int WIDTH_COEF = 16,
  parameter int TIMEOUT    = 1024,
  parameter int ADDR_W     = $clog2(ORDER + 1)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [WIDTH_COEF-1:0] s_data,
  input  logic                  sample_valid,
  output logic                  coef_wr,
  output logic [ADDR_W-1:0]     coef_addr,
  output logic [WIDTH_COEF-1:0] coef_data,
  output logic                  coef_mirr,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    LOAD        = 2'd1,
    WAIT_COMMIT = 2'd2,
    COMMIT      = 2'd3
  } state_e;

  // The timeout counter only ever needs to reach TIMEOUT-1.
  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

`ifdef FIR_COEF_SEQ_SYM_EN
  localparam logic [ADDR_W-1:0] ORDER_IDX = ADDR_W'(ORDER);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(ORDER / 2);
`else
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(ORDER);
`endif

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     tap_cnt_q, tap_cnt_d;
  logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
  logic                  err_q, err_d;
  logic                  wr_q, wr_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [WIDTH_COEF-1:0] data_q, data_d;
  logic                  mirr_q, mirr_d;
  logic                  done_q, done_d;
  logic                  accept;

`ifdef FIR_COEF_SEQ_SYM_EN
  // Set for the cycle in which the mirrored half of a tap pair is written.
  logic                  pend_q, pend_d;

  assign s_ready = (state_q == LOAD) && !pend_q;
`else
  assign s_ready = (state_q == LOAD);
`endif

  assign accept = s_valid && s_ready;

  always_comb begin
    state_d   = state_q;
    tap_cnt_d = tap_cnt_q;
    to_cnt_d  = to_cnt_q;
    err_d     = err_q;
    wr_d      = 1'b0;
    addr_d    = addr_q;
    data_d    = data_q;
    mirr_d    = 1'b0;
    done_d    = 1'b0;
`ifdef FIR_COEF_SEQ_SYM_EN
    pend_d    = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = LOAD;
          tap_cnt_d = '0;
          to_cnt_d  = '0;
          err_d     = 1'b0;
        end
      end

      LOAD: begin
`ifdef FIR_COEF_SEQ_SYM_EN
        if (pend_q) begin
          // Second write of the pair: same value, tap ORDER-k. data_q still
          // holds the value from the primary write.
          wr_d   = 1'b1;
          addr_d = ORDER_IDX - addr_q;
          if (addr_q == LAST_IDX) begin
            state_d = WAIT_COMMIT;
          end
        end else if (accept) begin
          wr_d   = 1'b1;
          addr_d = tap_cnt_q;
          data_d = s_data;
          // The centre tap of an even-order filter is its own mirror.
          pend_d = (tap_cnt_q != ORDER_IDX - tap_cnt_q);
          if (tap_cnt_q == LAST_IDX) begin
            if (tap_cnt_q == ORDER_IDX - tap_cnt_q) begin
              state_d = WAIT_COMMIT;
            end
          end else begin
            tap_cnt_d = tap_cnt_q + 1'b1;
          end
        end
`else
        if (accept) begin
          wr_d   = 1'b1;
          addr_d = tap_cnt_q;
          data_d = s_data;
          // Hold at the last index instead of wrapping.
          if (tap_cnt_q == LAST_IDX) begin
            state_d = WAIT_COMMIT;
          end else begin
            tap_cnt_d = tap_cnt_q + 1'b1;
          end
        end
`endif
        // Count consecutive idle stream cycles. An accepted beat always has
        // s_valid high, so it cannot coincide with a timeout.
        if (s_valid) begin
          to_cnt_d = '0;
        end else if (TIMEOUT > 0) begin
          if (to_cnt_q == TO_LAST) begin
            state_d = IDLE;
            err_d   = 1'b1;
          end else begin
            to_cnt_d = to_cnt_q + 1'b1;
          end
        end
      end

      WAIT_COMMIT: begin
        if (sample_valid) begin
          state_d = COMMIT;
          mirr_d  = 1'b1;
          done_d  = 1'b1;
        end
      end

      COMMIT: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      tap_cnt_q <= '0;
      to_cnt_q  <= '0;
      err_q     <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      mirr_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef FIR_COEF_SEQ_SYM_EN
      pend_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      tap_cnt_q <= tap_cnt_d;
      to_cnt_q  <= to_cnt_d;
      err_q     <= err_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      mirr_q    <= mirr_d;
      done_q    <= done_d;
`ifdef FIR_COEF_SEQ_SYM_EN
      pend_q    <= pend_d;
`endif
    end
  end

  assign coef_wr   = wr_q;
  assign coef_addr = addr_q;
  assign coef_data = data_q;
  assign coef_mirr = mirr_q;
  assign done      = done_q;
  assign err       = err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_fir_coef_seq.sv
// tb/tb_fir_coef_seq.sv - randomized self-checking bench for fir_coef_seq
module tb_fir_coef_seq;

  localparam int ORDER = 8;
  localparam int WC    = 16;
  localparam int TMO   = 16;
  localparam int AW    = 4;
`ifdef FIR_COEF_SEQ_SYM_EN
  localparam int NB    = ORDER / 2 + 1;
`else
  localparam int NB    = ORDER + 1;
`endif

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [WC-1:0] s_data = '0;
  logic          sample_valid = 1'b0;
  logic          coef_wr;
  logic [AW-1:0] coef_addr;
  logic [WC-1:0] coef_data;
  logic          coef_mirr;
  logic          busy;
  logic          done;
  logic          err;

  fir_coef_seq #(.ORDER(ORDER), .WIDTH_COEF(WC), .TIMEOUT(TMO), .ADDR_W(AW)) dut (
    .clk(clk), .resetn(resetn), .start(start), .s_valid(s_valid),
    .s_ready(s_ready), .s_data(s_data), .sample_valid(sample_valid),
    .coef_wr(coef_wr), .coef_addr(coef_addr), .coef_data(coef_data),
    .coef_mirr(coef_mirr), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  typedef struct { int c; int a; int d; } wr_t;
  typedef struct { int k; int a; int d; int off; } exp_t;

  int  cyc = 0;
  wr_t wr_log[$];
  int  acc_cyc[$];
  int  mirr_cnt = 0;
  int  done_cnt = 0;

  // Observe the bus away from the active edge.
  always @(negedge clk) begin
    cyc++;
    if (coef_wr) wr_log.push_back('{cyc, int'(coef_addr), int'(coef_data)});
    if (s_valid && s_ready) acc_cyc.push_back(cyc);
    if (coef_mirr) begin
      mirr_cnt++;
      check("mirr_vs_wr", 32'(coef_wr), 32'd0);
    end
    if (done) done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [WC-1:0] d);
    bit ok = 1'b0;
    s_valid = 1'b1;
    s_data  = d;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (s_ready) begin
        ok = 1'b1;
        break;
      end
    end
    tick();
    s_valid = 1'b0;
    check("beat_accepted", 32'(ok), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_s_ready"}, 32'(s_ready), 0);
    check({tag, "_coef_wr"}, 32'(coef_wr), 0);
    check({tag, "_coef_addr"}, 32'(coef_addr), 0);
    check({tag, "_coef_data"}, 32'(coef_data), 0);
    check({tag, "_coef_mirr"}, 32'(coef_mirr), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_err"}, 32'(err), 0);
  endtask

  // One complete load + commit. gap_fix<0 selects random gaps.
  task automatic run_load(input bit directed, input int gap_fix, input int sv_dly);
    logic [WC-1:0] beats[$];
    exp_t          exp_q[$];
    int            m0, d0, n;
    wr_log.delete();
    acc_cyc.delete();
    m0 = mirr_cnt;
    d0 = done_cnt;

    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", 32'(busy), 1);
    check("err_after_start", 32'(err), 0);
    check("s_ready_load", 32'(s_ready), 1);

    for (int k = 0; k < NB; k++) begin
      logic [WC-1:0] d;
      int            g;
      d = directed ? WC'(k + 1) : WC'($urandom);
      g = (gap_fix >= 0) ? gap_fix : $urandom_range(0, 4);
      if (k > 0) begin
        repeat (g) begin
          if (!directed) begin
            start        = 1'($urandom);
            sample_valid = 1'($urandom);
          end
          tick();
        end
      end
      start        = 1'b0;
      sample_valid = 1'b0;
      beats.push_back(d);
      send_beat(d);
    end

    // Waiting for the sample: stray beats and starts must be ignored.
    repeat (sv_dly) begin
      s_valid = directed ? 1'b0 : 1'($urandom);
      s_data  = WC'($urandom);
      start   = directed ? 1'b0 : 1'($urandom);
      tick();
    end
    s_valid = 1'b0;
    start   = 1'b0;
    check("no_mirr_before_sample", 32'(mirr_cnt - m0), 0);

    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    check("coef_mirr", 32'(coef_mirr), 1);
    check("done", 32'(done), 1);
    check("busy_commit", 32'(busy), 1);
    start = directed ? 1'b0 : 1'($urandom);
    tick();
    start = 1'b0;
    check("mirr_one_cycle", 32'(coef_mirr), 0);
    check("done_one_cycle", 32'(done), 0);
    check("busy_idle", 32'(busy), 0);
    check("s_ready_idle", 32'(s_ready), 0);
    check("err_clean", 32'(err), 0);
    tick();
    check("mirr_count", 32'(mirr_cnt - m0), 1);
    check("done_count", 32'(done_cnt - d0), 1);
    check("accept_count", 32'(acc_cyc.size()), 32'(NB));

    for (int k = 0; k < NB; k++) begin
      exp_q.push_back('{k, k, int'(beats[k]), 1});
`ifdef FIR_COEF_SEQ_SYM_EN
      if (k != ORDER - k) exp_q.push_back('{k, ORDER - k, int'(beats[k]), 2});
`endif
    end
    check("wr_count", 32'(wr_log.size()), 32'(exp_q.size()));
    n = (wr_log.size() < exp_q.size()) ? wr_log.size() : exp_q.size();
    for (int j = 0; j < n; j++) begin
      check("wr_addr", 32'(wr_log[j].a), 32'(exp_q[j].a));
      check("wr_data", 32'(wr_log[j].d), 32'(exp_q[j].d));
      if (exp_q[j].k < acc_cyc.size())
        check("wr_latency", 32'(wr_log[j].c), 32'(acc_cyc[exp_q[j].k] + exp_q[j].off));
    end
  endtask

  task automatic timeout_test();
    int m0;
    int nw;
    wr_log.delete();
    m0 = mirr_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) send_beat(WC'($urandom));
    // Now in the first stalled cycle.
    repeat (TMO - 1) tick();
    check("tmo_err_early", 32'(err), 0);
    check("tmo_busy_early", 32'(busy), 1);
    tick();
    check("tmo_err", 32'(err), 1);
    check("tmo_idle", 32'(busy), 0);
    check("tmo_s_ready", 32'(s_ready), 0);
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    repeat (3) tick();
    check("tmo_no_mirr", 32'(mirr_cnt - m0), 0);
    check("tmo_err_sticky", 32'(err), 1);
`ifdef FIR_COEF_SEQ_SYM_EN
    nw = 8;
`else
    nw = 4;
`endif
    check("tmo_writes", 32'(wr_log.size()), 32'(nw));
  endtask

  task automatic reset_test();
    int m0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 5; k++) send_beat(WC'(k + 1));
    #2;
    resetn = 1'b0;
    #1;
    check_all_zero("rst_mid");
    wr_log.delete();
    m0 = mirr_cnt;
    sample_valid = 1'b1;
    s_valid      = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    repeat (4) tick();
    sample_valid = 1'b0;
    s_valid      = 1'b0;
    tick();
    check("rst_no_wr", 32'(wr_log.size()), 0);
    check("rst_no_mirr", 32'(mirr_cnt - m0), 0);
    check("rst_busy", 32'(busy), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    #3;
    check_all_zero("rst_init");
    @(posedge clk);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    tick();
    check_all_zero("post_rst");

    run_load(1'b1, 0, 5);
    run_load(1'b0, 3, 2);
    run_load(1'b0, TMO - 1, 1);
    timeout_test();
    run_load(1'b0, -1, 3);
    for (int i = 0; i < 12; i++) run_load(1'b0, -1, $urandom_range(0, 6));
    reset_test();
    run_load(1'b0, -1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fir_coef_seq.md
FIR_COEF_SEQ -- requirements
Module: fir_coef_seq

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- ORDER, 8, FIR order; each set has ORDER+1 taps.
- WIDTH_COEF, 16, coefficient width.
- TIMEOUT, 1024, maximum idle cycles between stream beats during load; 0 disables the timeout.
- ADDR_W, $clog2(ORDER+1), width of the tap address.
REQ-002 Clocking SHALL be one clock; reset is asynchronous and active-low.
REQ-003 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, clock.
- resetn, in, 1, async active-low reset.
- start, in, 1, request to begin loading a coefficient set.
- s_valid, in, 1, coefficient stream valid.
- s_ready, out, 1, coefficient stream ready.
- s_data, in, WIDTH_COEF, coefficient; tap 0 first.
- sample_valid, in, 1, FIR input sample strobe; commit alignment.
- coef_wr, out, 1, one-cycle tap-write strobe to the FIR mirror.
- coef_addr, out, ADDR_W, tap index.
- coef_data, out, WIDTH_COEF, tap value.
- coef_mirr, out, 1, one-cycle commit of the mirror to the active taps.
- busy, out, 1, sequence in progress.
- done, out, 1, one-cycle strobe on commit completion.
- err, out, 1, sticky timeout flag; cleared by the next accepted start.

Function
REQ-004 The FSM SHALL have states IDLE, LOAD, WAIT_COMMIT and COMMIT.
REQ-005 In IDLE, start=1 SHALL move the FSM to LOAD, clear the tap counter, timeout counter and err, and set busy=1 in the next cycle.
REQ-006 start SHALL be ignored in every state other than IDLE.
REQ-007 s_ready SHALL be 1 only in LOAD and SHALL depend only on state.
REQ-008 Each beat accepted with s_valid&s_ready SHALL assert coef_wr exactly one cycle later (registered), with coef_addr equal to the tap counter and coef_data equal to s_data.
REQ-009 The tap counter SHALL increment on each accepted beat.
REQ-010 Acceptance of beat ORDER SHALL move the FSM to WAIT_COMMIT; no extra beats SHALL be accepted, and the counter SHALL NOT wrap.
REQ-011 In WAIT_COMMIT, the first cycle with sample_valid=1 SHALL move the FSM to COMMIT.
REQ-012 The coef_mirr pulse SHALL be issued from COMMIT.
REQ-013 coef_mirr SHALL be high for exactly one cycle, in the cycle after sample_valid was sampled.
REQ-014 coef_mirr SHALL never coincide with coef_wr; the last coef_wr precedes it by at least 1 cycle.
REQ-015 done SHALL pulse in the same cycle as coef_mirr; the FSM then returns to IDLE and busy=0 in the next cycle.
REQ-016 If TIMEOUT>0 and s_valid stays low for TIMEOUT consecutive LOAD cycles, the FSM SHALL:
- return to IDLE;
- set err=1;
- not assert coef_mirr or done.
Mirror taps already written SHALL be left as written.
REQ-017 sample_valid and s_valid arriving in the same cycle SHALL have no interaction, because each is sampled only in its own state.

Reset
REQ-018 resetn=0 SHALL asynchronously force state IDLE and all counters to 0.
REQ-019 During reset, outputs SHALL be s_ready=0, coef_wr=0, coef_addr=0, coef_data=0, coef_mirr=0, busy=0, done=0, err=0.
REQ-020 Reset asserted mid-load or mid-commit SHALL abort the sequence with no further coef_wr or coef_mirr.
REQ-021 Reset release SHALL be synchronous to clk.

Configuration
REQ-022 The macro FIR_COEF_SEQ_SYM_EN SHALL select symmetric loading.
- Defined: the stream carries ORDER/2+1 beats (integer division). Beat k writes tap k and, if k differs from ORDER-k, then tap ORDER-k in the following cycle. The stream stalls (s_ready=0) while the mirrored write is issued.
- Undefined: ORDER+1 beats, one write each, as in REQ-008.

Verification
REQ-023 The bench SHALL cover the following directed scenarios.
- ORDER=8, start, 9 back-to-back beats 1..9 -> coef_wr at addr 0..8 with data 1..9 on consecutive cycles; sample_valid 5 cycles later -> a single coef_mirr plus done; busy then drops.
- Beats with s_valid gaps of 3 cycles, TIMEOUT=1024 -> all 9 writes complete with no err.
- TIMEOUT=16, stall after 4 beats -> after 16 cycles err=1 and FSM in IDLE, with no coef_mirr; a new start clears err.
- resetn pulled low after 5 beats -> all outputs at 0 immediately; no coef_mirr follows.
- start pulsed during LOAD and WAIT_COMMIT -> no effect; the tap count stays correct.
- With FIR_COEF_SEQ_SYM_EN, ORDER=8, beats 1..5 -> writes (0,1),(8,1),(1,2),(7,2),(2,3),(6,3),(3,4),(5,4),(4,5), then coef_mirr.
